seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Consumer of the slow scan clock from the 7-segment clock divider: time-multiplexes
//  NUM_DIGITS hex digits onto one shared segment bus plus per-digit anodes.
//  Double-buffers display data so updates never tear mid-frame. Adds anti-ghost blanking
//  and optional leading-zero suppression. Sits between the CPU/debug value path and board pins.
// PARAMETERS
//  NUM_DIGITS    4   digits scanned; digit index width = clog2(NUM_DIGITS)
//  BLANK_CYCLES  16  clk cycles all anodes are off after each digit change (0 = no blanking)
// PORTS
//  clk        in   1             system clock (100 MHz); single clock domain
//  rst        in   1             synchronous, active-high reset
//  scan_clk   in   1             slow divider output; registered in clk domain, edge-detected
//  data_in    in   4*NUM_DIGITS  hex nibbles; digit 0 = [3:0]
//  dp_in      in   NUM_DIGITS    decimal-point request per digit
//  load       in   1             1-cycle strobe: capture data_in/dp_in into shadow
//  lz_en      in   1             leading-zero suppression enable
//  seg        out  7             segments {g,f,e,d,c,b,a}, active low
//  dp         out  1             decimal point, active low
//  an         out  NUM_DIGITS    digit anodes, active low, at most one low
//  frame_start out 1             1-cycle pulse when digit index wraps to 0
// BEHAVIOUR
//  Reset: seg=all 1, dp=1, an=all 1, frame_start=0, digit idx=0, shadow/active=0, pending=0, blank cnt=0.
//  Tick: sclk_q <= scan_clk; tick = scan_clk & ~sclk_q (rising edge only; level ignored).
//  On tick: idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1; blank cnt <= BLANK_CYCLES.
//  Blank: while blank cnt != 0, an = all 1 and cnt decrements each clk; seg/dp update meanwhile.
//  Active digit: an[idx]=0 only when blank cnt==0. All outputs registered: an/seg change
//   1 clk after tick (blanked) and become visible BLANK_CYCLES clks later.
//  Load: load=1 -> shadow <= {data_in,dp_in}, pending <= 1. Repeated loads: last wins.
//  Frame swap: on tick with idx wrapping to 0: if pending, active <= shadow, pending <= 0;
//   frame_start pulses same cycle idx becomes 0. load on that same cycle: data_in/dp_in
//   bypass directly into active, pending cleared (newest value wins, no frame lost).
//  Decode: seg = hex pattern of active nibble[idx] (0-F incl. A,b,C,d,E,F).
//  Leading-zero: lz_en=1 -> digit i>0 blanked (seg=all 1) if nibbles i..NUM_DIGITS-1 all zero;
//   digit 0 never blanked; dp follows dp bit regardless of blanking. an still scans.
//  Reset mid-operation: all state to reset values next clk; pending load discarded.
//  No scan_clk edges: display holds current digit steadily (no timeout).
// STRUCTURE
//  seg7_pkg: 16-entry hex->segment constant table, SEG_OFF=7'h7F, width helpers.
//  Sub-module seg7_hex_decode: combinational nibble->seg lookup from package table.
//  Top holds edge detect, idx counter, blank counter, shadow/active regs, output regs.
// TESTING (bench: NUM_DIGITS=4, BLANK_CYCLES=4, scan_clk driven as slow square wave)
//  1 Reset: rst=1 3 clks -> an=4'b1111, seg=7'h7F, dp=1, frame_start=0; held during rst.
//  2 Scan: load 16'h1234, run 2 frames -> 2nd frame an 1110/1101/1011/0111 with seg
//    7'b0011001(4)/7'b0110000(3)/7'b0100100(2)/7'b1111001(1).
//  3 Blank: after each scan_clk rise -> an=1111 for exactly 4 clks, then one anode low; only
//    rising edges advance idx.
//  4 Tear-free: load 16'hABCD while idx=2 -> digits 2,3 still old value; all digits new from
//    next frame_start; load coincident with wrap tick -> new value in that frame.
//  5 LZ: lz_en=1, data 16'h0040 -> digits 3,2 seg=7'h7F, digit1 '4', digit0 '0' (7'b1000000);
//    data 16'h0000 -> only digit 0 shows '0'; dp_in=4'b0100 -> dp=0 on digit 2 only.
//  6 Reset mid-frame: rst at idx=2 with pending load -> idx=0, active=0, pending dropped.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver.
// Hex glyph table plus width helpers.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; glyph n lives at bits [7n+6:7n].
  localparam logic [16*7-1:0] HEX_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to 7-segment glyph lookup.
// Output is active low, {g,f,e,d,c,b,a}.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_TABLE[7*nibble +: 7];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver with double-buffered data,
// anti-ghost blanking and optional leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_clk,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int BW = cnt_width(BLANK_CYCLES);

  logic                    sclk_q;
  logic                    tick;
  logic                    wrap;
  logic [IW-1:0]           idx;
  logic [BW-1:0]           blank_cnt;
  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] active_data;
  logic [NUM_DIGITS-1:0]   active_dp;
  logic [3:0]              nibble;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   zero_above;
  logic                    lz_blank;
  logic [NUM_DIGITS-1:0]   an_sel;

  // Sampled even in reset so a high scan_clk at release is not an edge.
  always_ff @(posedge clk) begin
    sclk_q <= scan_clk;
  end

  assign tick = scan_clk & ~sclk_q;
  assign wrap = (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      blank_cnt <= '0;
    end else if (tick) begin
      idx       <= wrap ? '0 : idx + 1'b1;
      blank_cnt <= BW'(BLANK_CYCLES);
    end else if (blank_cnt != '0) begin
      blank_cnt <= blank_cnt - 1'b1;
    end
  end

  // A load landing on the wrap tick bypasses the shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      pending     <= 1'b0;
      active_data <= '0;
      active_dp   <= '0;
    end else if (tick && wrap && load) begin
      active_data <= data_in;
      active_dp   <= dp_in;
      pending     <= 1'b0;
    end else if (tick && wrap && pending) begin
      active_data <= shadow_data;
      active_dp   <= shadow_dp;
      pending     <= 1'b0;
    end else if (load) begin
      shadow_data <= data_in;
      shadow_dp   <= dp_in;
      pending     <= 1'b1;
    end
  end

  always_comb begin
    nibble = active_data[4*idx +: 4];
  end

  seg7_hex_decode u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  // zero_above[i]: nibbles i..top are all zero.
  always_comb begin
    logic z;
    z = 1'b1;
    zero_above = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z = z & (active_data[4*i +: 4] == 4'h0);
      zero_above[i] = z;
    end
  end

  assign lz_blank = lz_en && (idx != '0) && zero_above[idx];

  always_comb begin
    an_sel      = '1;
    an_sel[idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      an          <= '1;
      frame_start <= 1'b0;
    end else begin
      seg         <= lz_blank ? SEG_OFF : dec_seg;
      dp          <= ~active_dp[idx];
      an          <= (blank_cnt != '0) ? '1 : an_sel;
      frame_start <= tick & wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised self-checking bench for seg7_scan_driver
// against a digit-level display model.
module tb_seg7_scan_driver;

  localparam int N = 4;
  localparam int B = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_clk;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        lz_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_idx;
  logic [15:0] m_data, m_sh_data;
  logic [3:0]  m_dp, m_sh_dp;
  bit          m_pend;

  seg7_scan_driver #(
    .NUM_DIGITS   (N),
    .BLANK_CYCLES (B)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_clk    (scan_clk),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .load        (load),
    .lz_en       (lz_en),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg();
    int i;
    i = m_idx;
    if (lz_en && i > 0 && (m_data >> (4*i)) == 16'h0)
      return 7'h7F;
    return hex7(m_data[4*i +: 4]);
  endfunction

  task automatic check_digit(input string tag);
    logic [3:0] ea;
    logic       ed;
    ea = 4'hF;
    ea[m_idx] = 1'b0;
    ed = ~m_dp[m_idx];
    chk({tag, "_an"}, an, ea);
    chk({tag, "_seg"}, seg, exp_seg());
    chk({tag, "_dp"}, dp, ed);
  endtask

  task automatic model_reset();
    m_idx = 0;
    m_data = '0;
    m_dp = '0;
    m_sh_data = '0;
    m_sh_dp = '0;
    m_pend = 0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    load = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1'b1);
      chk("rst_fs", frame_start, 1'b0);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_digit("post_rst");
  endtask

  task automatic scan_step(input bit ld, input logic [15:0] d,
                           input logic [3:0] p);
    bit wrap;
    @(negedge clk);
    scan_clk = 1'b1;
    load = ld;
    data_in = d;
    dp_in = p;
    @(negedge clk);
    load = 1'b0;
    wrap = (m_idx == N - 1);
    m_idx = (m_idx + 1) % N;
    if (wrap && ld) begin
      m_data = d;
      m_dp = p;
      m_pend = 0;
    end else if (wrap && m_pend) begin
      m_data = m_sh_data;
      m_dp = m_sh_dp;
      m_pend = 0;
    end else if (ld) begin
      m_sh_data = d;
      m_sh_dp = p;
      m_pend = 1;
    end
    chk("frame_start", frame_start, wrap);
    for (int k = 0; k < B; k++) begin
      @(negedge clk);
      if (k == 1) scan_clk = 1'b0;
      chk("blank_an", an, 4'hF);
    end
    @(negedge clk);
    check_digit("digit");
    chk("fs_low", frame_start, 1'b0);
  endtask

  task automatic load_only(input logic [15:0] d, input logic [3:0] p);
    @(negedge clk);
    load = 1'b1;
    data_in = d;
    dp_in = p;
    @(negedge clk);
    load = 1'b0;
    m_sh_data = d;
    m_sh_dp = p;
    m_pend = 1;
    @(negedge clk);
    check_digit("hold");
  endtask

  task automatic step_to(input int target);
    int guard;
    guard = 0;
    while (m_idx != target && guard < N) begin
      scan_step(0, 16'h0, 4'h0);
      guard++;
    end
  endtask

  initial begin
    rst = 1'b0;
    scan_clk = 1'b0;
    data_in = '0;
    dp_in = '0;
    load = 1'b0;
    lz_en = 1'b0;
    model_reset();

    do_reset(3);

    // Basic scan across two frames
    load_only(16'h1234, 4'h0);
    repeat (8) scan_step(0, 16'h0, 4'h0);

    // Idle: digit held steady without scan edges
    repeat (6) @(negedge clk);
    check_digit("idle");

    // Tear-free mid-frame load, then load on the wrap tick
    step_to(2);
    load_only(16'hABCD, 4'h0);
    repeat (4) scan_step(0, 16'h0, 4'h0);
    step_to(3);
    scan_step(1, 16'h5678, 4'h3);
    repeat (4) scan_step(0, 16'h0, 4'h0);

    // Leading-zero suppression
    lz_en = 1'b1;
    load_only(16'h0040, 4'b0100);
    repeat (8) scan_step(0, 16'h0, 4'h0);
    load_only(16'h0000, 4'b0100);
    repeat (8) scan_step(0, 16'h0, 4'h0);
    lz_en = 1'b0;

    // Reset mid-frame drops a pending load
    load_only(16'h9F9F, 4'hF);
    repeat (5) scan_step(0, 16'h0, 4'h0);
    step_to(2);
    load_only(16'hEEEE, 4'hF);
    do_reset(1);
    repeat (6) scan_step(0, 16'h0, 4'h0);

    // Randomised traffic
    for (int r = 0; r < 80; r++) begin
      lz_en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) begin
        logic [15:0] d;
        d = 16'($urandom);
        if ($urandom_range(0, 1) == 1) d = d & 16'h00FF;
        load_only(d, 4'($urandom));
      end
      scan_step($urandom_range(0, 3) == 0, 16'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
